// File: rtl/tq_enq_responder_if.sv
// rtl/tq_enq_responder_if.sv - enqueue, task-queue write, slot free and response signals of tq_enq_responder
interface tq_enq_responder_if #(
    parameter int LOG_TQ_SIZE = 6,
    parameter int EPOCH_W     = 8,
    parameter int TASK_W      = 32,
    parameter int TSB_ID_W    = 6,
    parameter int TILE_W      = 4
);
    logic                   task_enq_valid;
    logic                   task_enq_ready;
    logic [TASK_W-1:0]      task_enq_data;
    logic                   task_enq_tied;
    logic [TSB_ID_W-1:0]    task_enq_tsb_id;
    logic [TILE_W-1:0]      task_enq_src_tile;

    logic                   tq_wvalid;
    logic                   tq_wready;
    logic [TASK_W-1:0]      tq_wdata;
    logic [LOG_TQ_SIZE-1:0] tq_wslot;

    logic                   tq_free_valid;
    logic [LOG_TQ_SIZE-1:0] tq_free_slot;

    logic                   task_resp_valid;
    logic                   task_resp_ready;
    logic                   task_resp_ack;
    logic [TSB_ID_W-1:0]    task_resp_tsb_id;
    logic [EPOCH_W-1:0]     task_resp_epoch;
    logic [LOG_TQ_SIZE-1:0] task_resp_tq_slot;
    logic [TILE_W-1:0]      task_resp_dest_tile;

    modport master (
        output task_enq_valid, task_enq_data, task_enq_tied, task_enq_tsb_id, task_enq_src_tile,
        output tq_wready, tq_free_valid, tq_free_slot, task_resp_ready,
        input  task_enq_ready, tq_wvalid, tq_wdata, tq_wslot,
        input  task_resp_valid, task_resp_ack, task_resp_tsb_id, task_resp_epoch,
        input  task_resp_tq_slot, task_resp_dest_tile
    );

    modport slave (
        input  task_enq_valid, task_enq_data, task_enq_tied, task_enq_tsb_id, task_enq_src_tile,
        input  tq_wready, tq_free_valid, tq_free_slot, task_resp_ready,
        output task_enq_ready, tq_wvalid, tq_wdata, tq_wslot,
        output task_resp_valid, task_resp_ack, task_resp_tsb_id, task_resp_epoch,
        output task_resp_tq_slot, task_resp_dest_tile
    );
endinterface

// File: rtl/tq_enq_responder.sv
// rtl/tq_enq_responder.sv - task-queue slot allocator with per-slot epochs and tied ack/nack responses
// Optional macro TQ_UNTIED_RESERVE_EN keeps the last 4 free slots for untied tasks.
module tq_enq_responder #(
    parameter int LOG_TQ_SIZE = 6,
    parameter int EPOCH_W     = 8,
    parameter int TASK_W      = 32,
    parameter int TSB_ID_W    = 6,
    parameter int TILE_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tq_enq_responder_if.slave    bus,
    output logic [LOG_TQ_SIZE:0] n_free,
    output logic                 empty
);
    localparam int TQ_SIZE = 1 << LOG_TQ_SIZE;
    localparam logic [LOG_TQ_SIZE:0] TQ_SIZE_V = (LOG_TQ_SIZE+1)'(TQ_SIZE);
`ifdef TQ_UNTIED_RESERVE_EN
    localparam logic [LOG_TQ_SIZE:0] TIED_RESERVE = (LOG_TQ_SIZE+1)'(4);
`else
    localparam logic [LOG_TQ_SIZE:0] TIED_RESERVE = '0;
`endif

    logic [TQ_SIZE-1:0]     alloc_bm;
    logic [EPOCH_W-1:0]     epoch [TQ_SIZE];
    logic [LOG_TQ_SIZE:0]   n_free_q;

    logic                   wvalid_q;
    logic [TASK_W-1:0]      wdata_q;
    logic [LOG_TQ_SIZE-1:0] wslot_q;
    logic                   rvalid_q;
    logic                   rack_q;
    logic [TSB_ID_W-1:0]    rtsb_q;
    logic [EPOCH_W-1:0]     repoch_q;
    logic [LOG_TQ_SIZE-1:0] rslot_q;
    logic [TILE_W-1:0]      rtile_q;

    logic                   free_found;
    logic [LOG_TQ_SIZE-1:0] free_idx;
    logic                   eligible;
    logic                   out_ok;
    logic                   accept;
    logic                   do_alloc;
    logic                   free_hit;

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = TQ_SIZE - 1; i >= 0; i--) begin
            if (!alloc_bm[i]) begin
                free_found = 1'b1;
                free_idx   = LOG_TQ_SIZE'(i);
            end
        end
    end

    assign eligible = bus.task_enq_tied ? (free_found && (n_free_q > TIED_RESERVE)) : free_found;
    assign out_ok   = (!wvalid_q || bus.tq_wready) && (!rvalid_q || bus.task_resp_ready);
    assign bus.task_enq_ready = !rst && out_ok && (eligible || bus.task_enq_tied);
    assign accept   = bus.task_enq_valid && bus.task_enq_ready;
    assign do_alloc = accept && eligible;
    // A freshly allocated slot was free before this edge, so it can never also be the freed slot.
    assign free_hit = bus.tq_free_valid && alloc_bm[bus.tq_free_slot];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_bm <= '0;
            n_free_q <= TQ_SIZE_V;
            for (int i = 0; i < TQ_SIZE; i++) epoch[i] <= '0;
        end else begin
            if (do_alloc) alloc_bm[free_idx] <= 1'b1;
            if (free_hit) begin
                alloc_bm[bus.tq_free_slot] <= 1'b0;
                epoch[bus.tq_free_slot]    <= epoch[bus.tq_free_slot] + 1'b1;
            end
            n_free_q <= n_free_q + (LOG_TQ_SIZE+1)'(free_hit) - (LOG_TQ_SIZE+1)'(do_alloc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
            wslot_q  <= '0;
        end else if (do_alloc) begin
            wvalid_q <= 1'b1;
            wdata_q  <= bus.task_enq_data;
            wslot_q  <= free_idx;
        end else if (bus.tq_wready) begin
            wvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rack_q   <= 1'b0;
            rtsb_q   <= '0;
            repoch_q <= '0;
            rslot_q  <= '0;
            rtile_q  <= '0;
        end else if (accept && bus.task_enq_tied) begin
            rvalid_q <= 1'b1;
            rack_q   <= eligible;
            rtsb_q   <= bus.task_enq_tsb_id;
            repoch_q <= eligible ? epoch[free_idx] : '0;
            rslot_q  <= eligible ? free_idx : '0;
            rtile_q  <= bus.task_enq_src_tile;
        end else if (bus.task_resp_ready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign bus.tq_wvalid           = wvalid_q;
    assign bus.tq_wdata            = wdata_q;
    assign bus.tq_wslot            = wslot_q;
    assign bus.task_resp_valid     = rvalid_q;
    assign bus.task_resp_ack       = rack_q;
    assign bus.task_resp_tsb_id    = rtsb_q;
    assign bus.task_resp_epoch     = repoch_q;
    assign bus.task_resp_tq_slot   = rslot_q;
    assign bus.task_resp_dest_tile = rtile_q;
    assign n_free = n_free_q;
    assign empty  = (n_free_q == TQ_SIZE_V);
endmodule

// File: tb/tb_tq_enq_responder.sv
// tb/tb_tq_enq_responder.sv - directed bench for tq_enq_responder with a slot/epoch reference model
module tb_tq_enq_responder;
    localparam int LOG = 6;
    localparam int EW  = 8;
    localparam int DW  = 32;
    localparam int TW  = 6;
    localparam int LW  = 4;
    localparam int N   = 1 << LOG;

    logic clk;
    logic rst;
    logic [LOG:0] n_free;
    logic empty;

    tq_enq_responder_if #(.LOG_TQ_SIZE(LOG), .EPOCH_W(EW), .TASK_W(DW), .TSB_ID_W(TW), .TILE_W(LW)) bus ();

    tq_enq_responder #(.LOG_TQ_SIZE(LOG), .EPOCH_W(EW), .TASK_W(DW), .TSB_ID_W(TW), .TILE_W(LW)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .n_free(n_free), .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot ownership and epochs as plain arrays, outputs as the values they must show.
    bit          m_alloc [N];
    int          m_ep    [N];
    bit          m_wv, m_rv, m_ack;
    int          m_wslot, m_rslot, m_rep, m_tsb, m_tile;
    logic [DW-1:0] m_wdata;

    function automatic int m_nfree();
        int c = 0;
        for (int i = 0; i < N; i++) if (!m_alloc[i]) c++;
        return c;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < N; i++) if (!m_alloc[i]) return i;
        return -1;
    endfunction

    function automatic bit m_elig(input bit tied);
`ifdef TQ_UNTIED_RESERVE_EN
        return tied ? (m_nfree() > 4) : (m_nfree() > 0);
`else
        return m_nfree() > 0;
`endif
    endfunction

    function automatic bit m_ready();
        if (rst) return 1'b0;
        return (!m_wv || bus.tq_wready) && (!m_rv || bus.task_resp_ready)
               && (m_elig(bus.task_enq_tied) || bus.task_enq_tied);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_alloc[i] = 1'b0;
            m_ep[i] = 0;
        end
        m_wv = 0; m_rv = 0; m_ack = 0;
    endtask

    task automatic m_step();
        bit acc, el, fr;
        int s, fs;
        acc = bus.task_enq_valid && m_ready();
        el  = m_elig(bus.task_enq_tied);
        s   = m_lowest();
        fs  = int'(bus.tq_free_slot);
        fr  = bus.tq_free_valid && m_alloc[fs];
        if (acc && el) begin
            m_wv = 1; m_wslot = s; m_wdata = bus.task_enq_data;
        end else if (bus.tq_wready) m_wv = 0;
        if (acc && bus.task_enq_tied) begin
            m_rv = 1; m_ack = el;
            m_rep = el ? m_ep[s] : 0;
            m_rslot = el ? s : 0;
            m_tsb = int'(bus.task_enq_tsb_id);
            m_tile = int'(bus.task_enq_src_tile);
        end else if (bus.task_resp_ready) m_rv = 0;
        if (acc && el) m_alloc[s] = 1'b1;
        if (fr) begin
            m_alloc[fs] = 1'b0;
            m_ep[fs] = (m_ep[fs] + 1) % (1 << EW);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("enq_ready", bus.task_enq_ready, m_ready());
            chk("tq_wvalid", bus.tq_wvalid, m_wv);
            if (m_wv) begin
                chk("tq_wslot", bus.tq_wslot, m_wslot);
                chk("tq_wdata", bus.tq_wdata, m_wdata);
            end
            chk("resp_valid", bus.task_resp_valid, m_rv);
            if (m_rv) begin
                chk("resp_ack", bus.task_resp_ack, m_ack);
                chk("resp_tsb_id", bus.task_resp_tsb_id, m_tsb);
                chk("resp_epoch", bus.task_resp_epoch, m_rep);
                chk("resp_tq_slot", bus.task_resp_tq_slot, m_rslot);
                chk("resp_dest_tile", bus.task_resp_dest_tile, m_tile);
            end
            chk("n_free", n_free, m_nfree());
            chk("empty", empty, m_nfree() == N);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input bit tied, input int tsb, input int tile, input logic [DW-1:0] data);
        bus.task_enq_valid    = 1'b1;
        bus.task_enq_tied     = tied;
        bus.task_enq_tsb_id   = TW'(tsb);
        bus.task_enq_src_tile = LW'(tile);
        bus.task_enq_data     = data;
    endtask

    task automatic enq(input bit tied, input int tsb, input int tile, input logic [DW-1:0] data);
        set_enq(tied, tsb, tile, data);
        tick();
        bus.task_enq_valid = 1'b0;
    endtask

    task automatic free_slot(input int s);
        bus.tq_free_valid = 1'b1;
        bus.tq_free_slot  = LOG'(s);
        tick();
        bus.tq_free_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.task_enq_valid = 0; bus.task_enq_tied = 0; bus.task_enq_tsb_id = '0;
        bus.task_enq_src_tile = '0; bus.task_enq_data = '0;
        bus.tq_wready = 1; bus.tq_free_valid = 0; bus.tq_free_slot = '0; bus.task_resp_ready = 1;
        do_reset();
        chk("reset_n_free", n_free, 64);
        chk("reset_empty", empty, 1);
        chk("reset_wvalid", bus.tq_wvalid, 0);
        chk("reset_resp_valid", bus.task_resp_valid, 0);
        chk("reset_resp_ack", bus.task_resp_ack, 0);

        // First tied enqueue after reset
        enq(1, 5, 2, 32'h0000_00A5);
        chk("first_wvalid", bus.tq_wvalid, 1);
        chk("first_wslot", bus.tq_wslot, 0);
        chk("first_ack", bus.task_resp_ack, 1);
        chk("first_epoch", bus.task_resp_epoch, 0);
        chk("first_slot", bus.task_resp_tq_slot, 0);
        chk("first_tsb", bus.task_resp_tsb_id, 5);
        chk("first_tile", bus.task_resp_dest_tile, 2);
        tick();

        // Response held by back-pressure: fields stable, enqueue blocked
        bus.task_resp_ready = 0;
        set_enq(1, 3, 7, 32'h1111_2222);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_ready", bus.task_enq_ready, 0);
            chk("hold_valid", bus.task_resp_valid, 1);
            chk("hold_tsb", bus.task_resp_tsb_id, 3);
            chk("hold_slot", bus.task_resp_tq_slot, 1);
            tick();
        end
        bus.task_enq_valid = 0;
        bus.task_resp_ready = 1;
        tick();

        // Slots 2..8 busy, free 8, then free 7 alongside an allocation
        for (int i = 0; i < 7; i++) enq(0, 0, 0, DW'(32'h100 + i));
        free_slot(8);
        bus.tq_free_valid = 1'b1;
        bus.tq_free_slot  = LOG'(7);
        enq(0, 0, 0, 32'hCAFE_0008);
        bus.tq_free_valid = 1'b0;
        chk("same_cycle_slot", bus.tq_wslot, 8);
        enq(0, 0, 0, 32'hCAFE_0007);
        chk("next_slot", bus.tq_wslot, 7);
        free_slot(20);
        chk("free_unalloc_n_free", n_free, 55);

        // Task-queue write back-pressure
        bus.tq_wready = 0;
        enq(0, 0, 0, 32'hBEEF_0009);
        set_enq(0, 0, 0, 32'hBEEF_000A);
        #1;
        chk("wbp_ready", bus.task_enq_ready, 0);
        tick();
        chk("wbp_slot", bus.tq_wslot, 9);
        bus.tq_wready = 1;
        tick();
        bus.task_enq_valid = 0;
        chk("wbp_after_slot", bus.tq_wslot, 10);
        tick();

        // Full queue: tied nack, untied stalls until a slot is freed
        do_reset();
        for (int i = 0; i < N; i++) enq(0, 0, 0, DW'(i));
        chk("full_n_free", n_free, 0);
        enq(1, 9, 1, 32'hDEAD);
        chk("full_ack", bus.task_resp_ack, 0);
        chk("full_resp_valid", bus.task_resp_valid, 1);
        chk("full_slot", bus.task_resp_tq_slot, 0);
        chk("full_epoch", bus.task_resp_epoch, 0);
        chk("full_wvalid", bus.tq_wvalid, 0);
        set_enq(0, 0, 0, 32'h5555);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_untied_ready", bus.task_enq_ready, 0);
            tick();
        end
        free_slot(5);
        tick();
        bus.task_enq_valid = 0;
        chk("full_refill_slot", bus.tq_wslot, 5);
        tick();

        // Reserve threshold at n_free == 4
        do_reset();
        for (int i = 0; i < 60; i++) enq(0, 0, 0, DW'(i));
        chk("res_n_free", n_free, 4);
        enq(1, 1, 3, 32'h7777);
`ifdef TQ_UNTIED_RESERVE_EN
        chk("res_tied_ack", bus.task_resp_ack, 0);
        enq(0, 0, 0, 32'h8888);
        chk("res_untied_slot", bus.tq_wslot, 60);
        chk("res_untied_n_free", n_free, 3);
`else
        chk("res_tied_ack", bus.task_resp_ack, 1);
        enq(0, 0, 0, 32'h8888);
        chk("res_untied_slot", bus.tq_wslot, 61);
        chk("res_untied_n_free", n_free, 2);
`endif
        tick();

        // Epoch wrap on slot 3
        do_reset();
        for (int i = 0; i < 4; i++) enq(0, 0, 0, DW'(i));
        for (int k = 1; k <= 256; k++) begin
            free_slot(3);
            enq(1, k % 64, k % 16, DW'(k));
            if (k == 255) chk("epoch_255", bus.task_resp_epoch, 255);
            if (k == 256) begin
                chk("epoch_wrap", bus.task_resp_epoch, 0);
                chk("epoch_wrap_slot", bus.task_resp_tq_slot, 3);
            end
        end
        tick();

        // Reset mid-transaction discards pending write and response
        bus.tq_wready = 0;
        bus.task_resp_ready = 0;
        enq(1, 4, 4, 32'h4444);
        set_enq(0, 0, 0, 32'h4545);
        rst = 1'b1;
        #1;
        chk("rst_ready", bus.task_enq_ready, 0);
        chk("rst_wvalid", bus.tq_wvalid, 0);
        chk("rst_resp_valid", bus.task_resp_valid, 0);
        chk("rst_n_free", n_free, 64);
        tick();
        bus.task_enq_valid = 0;
        bus.tq_wready = 1;
        bus.task_resp_ready = 1;
        rst = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
